// File: rtl/wavesense_stf_pkg.sv
// Shared constants and types for the 802.11a short training field generator.
package wavesense_stf_pkg;

  localparam int unsigned STF_LEN  = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned COMP_W   = 16;
  localparam int unsigned SAMPLE_W = 2 * COMP_W;

  // I occupies the upper half of the packed word, Q the lower half.
  typedef struct packed {
    logic signed [COMP_W-1:0] i;
    logic signed [COMP_W-1:0] q;
  } iq_sample_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Short symbol in Q1.15.
  localparam logic signed [COMP_W-1:0] STF_I [STF_LEN] = '{
    16'sd1507, -16'sd4325, -16'sd426,  16'sd4686,
    16'sd3015,  16'sd4686, -16'sd426, -16'sd4325,
    16'sd1507,  16'sd66,   -16'sd2589, -16'sd426,
    16'sd0,    -16'sd426,  -16'sd2589, 16'sd66
  };

  localparam logic signed [COMP_W-1:0] STF_Q [STF_LEN] = '{
    16'sd1507,  16'sd66,   -16'sd2589, -16'sd426,
    16'sd0,    -16'sd426,  -16'sd2589,  16'sd66,
    16'sd1507, -16'sd4325, -16'sd426,   16'sd4686,
    16'sd3015,  16'sd4686, -16'sd426,  -16'sd4325
  };

endpackage

// File: rtl/stf_rom.sv
// Short-symbol lookup with a fixed arithmetic gain shift.
//   idx       in   4   sample index within the 16-sample short symbol
//   sample_c  out  32  scaled I/Q sample (combinational)
module stf_rom
  import wavesense_stf_pkg::*;
#(
  parameter int unsigned GAIN_SHIFT = 0
) (
  input  logic [IDX_W-1:0] idx,
  output iq_sample_t       sample_c
);

  // Arithmetic shift keeps the sign; magnitudes stay below 2^13, so no clipping.
  always_comb begin
    sample_c   = '0;
    sample_c.i = STF_I[idx] >>> GAIN_SHIFT;
    sample_c.q = STF_Q[idx] >>> GAIN_SHIFT;
  end

endmodule

// File: rtl/stf_generator.sv
// Streams NUM_REPS repetitions of the 802.11a short symbol over valid/ready.
//   clk_in, rst_n_in   clock, async active-low reset
//   start_in           starts a burst (IDLE only)
//   abort_in           ends the burst immediately, highest priority
//   sample_out         {I[31:16], Q[15:0]} two's complement
//   sample_out_valid   sample_out holds a sample
//   sample_out_ready   downstream accepts
//   sample_out_last    marks the final sample of the burst
//   busy_out           high in RUN and DONE
//   done_out           one-cycle pulse after the final transfer
module stf_generator
  import wavesense_stf_pkg::*;
#(
  parameter int unsigned NUM_REPS   = 10,
  parameter int unsigned GAIN_SHIFT = 0
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start_in,
  input  logic                abort_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid,
  input  logic                sample_out_ready,
  output logic                sample_out_last,
  output logic                busy_out,
  output logic                done_out
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STF_LEN - 1);
  localparam logic [IDX_W-1:0] REP_LAST = IDX_W'(NUM_REPS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rep;
  logic [IDX_W-1:0] next_idx_c;
  logic [IDX_W-1:0] next_rep_c;
  logic [IDX_W-1:0] rom_idx_c;
  logic             xfer_c;
  iq_sample_t       rom_sample_c;

  assign xfer_c = sample_out_valid && sample_out_ready;

  // Counter successors; the ROM looks up the sample that will be loaded next.
  always_comb begin
    next_idx_c = idx + IDX_W'(1);
    next_rep_c = (idx == IDX_LAST) ? rep + IDX_W'(1) : rep;
    rom_idx_c  = (state == ST_RUN) ? next_idx_c : '0;
  end

  stf_rom #(
    .GAIN_SHIFT(GAIN_SHIFT)
  ) u_rom (
    .idx      (rom_idx_c),
    .sample_c (rom_sample_c)
  );

  // Burst FSM, counters and output register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= ST_IDLE;
      idx              <= '0;
      rep              <= '0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      sample_out_last  <= 1'b0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
    end else if (abort_in) begin
      state            <= ST_IDLE;
      idx              <= '0;
      rep              <= '0;
      sample_out_valid <= 1'b0;
      sample_out_last  <= 1'b0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            state            <= ST_RUN;
            idx              <= '0;
            rep              <= '0;
            sample_out       <= rom_sample_c;
            sample_out_valid <= 1'b1;
            sample_out_last  <= 1'b0;
            busy_out         <= 1'b1;
          end
        end
        ST_RUN: begin
          if (xfer_c) begin
            if (sample_out_last) begin
              state            <= ST_DONE;
              idx              <= '0;
              rep              <= '0;
              sample_out_valid <= 1'b0;
              sample_out_last  <= 1'b0;
              done_out         <= 1'b1;
            end else begin
              idx             <= next_idx_c;
              rep             <= next_rep_c;
              sample_out      <= rom_sample_c;
              sample_out_last <= (next_idx_c == IDX_LAST) && (next_rep_c == REP_LAST);
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          done_out <= 1'b0;
          busy_out <= 1'b0;
        end
        default: begin
          state            <= ST_IDLE;
          sample_out_valid <= 1'b0;
          sample_out_last  <= 1'b0;
          busy_out         <= 1'b0;
          done_out         <= 1'b0;
        end
      endcase
    end
  end

endmodule
